// File: rtl/iq_ser_pkg.sv
// -----------------------------------------------------------------------------
// iq_ser_pkg
// Shared definitions for the I/Q frame serializer:
//   - default frame geometry (channels, sample width, channels per beat)
//   - derived beats per frame at the defaults
//   - header tag carried in bits [31:16] of the optional header beat
//   - output FSM state encoding
// Optional feature macro used by the serializer: IQ_FRAME_SERIALIZER_HDR_EN
// -----------------------------------------------------------------------------
package iq_ser_pkg;

   localparam int NUM_CH_DEF      = 128;
   localparam int SAMPLE_W_DEF    = 10;
   localparam int CH_PER_BEAT_DEF = 16;
   localparam int BEATS_PER_FRAME = NUM_CH_DEF / CH_PER_BEAT_DEF;

   localparam logic [15:0] HDR_TAG = 16'hA5C3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HDR,
      ST_SEND
   } ser_state_t;

endpackage

// File: rtl/iq_frame_buffer.sv
// -----------------------------------------------------------------------------
// iq_frame_buffer
// Two-slot frame store for the serializer. Frames leave in arrival order.
// Ports:
//   clk_i, reset_ni          clock, asynchronous active-low reset
//   push_req                 upstream frame strobe
//   pop                      head frame fully sent (eof beat transferred)
//   wr_i_data, wr_q_data     incoming I / Q frame
//   rd_i_data, rd_q_data     head-of-queue I / Q frame
//   occ                      occupancy 0..2
//   accept                   push_req taken this cycle
//   drop                     push_req refused (buffer full, no slot freed)
// -----------------------------------------------------------------------------
module iq_frame_buffer #(
   parameter int FRAME_W = 1280
) (
   input  logic               clk_i,
   input  logic               reset_ni,
   input  logic               push_req,
   input  logic               pop,
   input  logic [FRAME_W-1:0] wr_i_data,
   input  logic [FRAME_W-1:0] wr_q_data,
   output logic [FRAME_W-1:0] rd_i_data,
   output logic [FRAME_W-1:0] rd_q_data,
   output logic [1:0]         occ,
   output logic               accept,
   output logic               drop
);

   logic               wr_ptr;
   logic               rd_ptr;
   logic               full;
   logic [FRAME_W-1:0] slot_i [2];
   logic [FRAME_W-1:0] slot_q [2];

   // A pop in the same cycle frees the head slot, so a full buffer can still
   // take the incoming frame (write lands in the slot being vacated).
   assign full   = (occ == 2'd2);
   assign accept = push_req & (~full | pop);
   assign drop   = push_req & full & ~pop;

   // NOTE: the frame slots carry no reset; occ/pointers decide what is valid,
   // so resetting wide data storage would only cost area and routing.
   always_ff @(posedge clk_i) begin
      if (accept) begin
         slot_i[wr_ptr] <= wr_i_data;
         slot_q[wr_ptr] <= wr_q_data;
      end
   end

   // 1-bit pointers wrap modulo 2 by construction.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         occ    <= 2'd0;
      end else begin
         if (accept) wr_ptr <= ~wr_ptr;
         if (pop)    rd_ptr <= ~rd_ptr;
         occ <= occ + 2'(accept) - 2'(pop);
      end
   end

   assign rd_i_data = slot_i[rd_ptr];
   assign rd_q_data = slot_q[rd_ptr];

endmodule

// File: rtl/iq_frame_serializer.sv
// -----------------------------------------------------------------------------
// iq_frame_serializer
// Buffers whole I/Q frames (2 slots) and streams them as beats of CH_PER_BEAT
// channels, I/Q interleaved per lane, with valid/ready handshake.
// Ports:
//   clk_i, reset_ni     clock, asynchronous active-low reset
//   I_data_i, Q_data_i  input frame, channel c at [SAMPLE_W*c +: SAMPLE_W]
//   data_valid_i        single-cycle frame strobe
//   data_o              output beat, lane k: I at [2*SAMPLE_W*k +: SAMPLE_W],
//                       Q in the next SAMPLE_W bits
//   data_valid_o        beat valid (registered, independent of data_ready_i)
//   data_ready_i        downstream ready
//   sof_o, eof_o        first / last beat of a frame
//   overflow_o          sticky frame-dropped flag, cleared only by reset
// Optional: IQ_FRAME_SERIALIZER_HDR_EN adds one header beat per frame
//   (bits[15:0] frame count, bits[31:16] HDR_TAG, rest 0; sof on header).
// -----------------------------------------------------------------------------
module iq_frame_serializer
   import iq_ser_pkg::*;
#(
   parameter int NUM_CH      = NUM_CH_DEF,
   parameter int SAMPLE_W    = SAMPLE_W_DEF,
   parameter int CH_PER_BEAT = CH_PER_BEAT_DEF
) (
   input  logic                            clk_i,
   input  logic                            reset_ni,
   input  logic [NUM_CH*SAMPLE_W-1:0]      I_data_i,
   input  logic [NUM_CH*SAMPLE_W-1:0]      Q_data_i,
   input  logic                            data_valid_i,
   output logic [CH_PER_BEAT*2*SAMPLE_W-1:0] data_o,
   output logic                            data_valid_o,
   input  logic                            data_ready_i,
   output logic                            sof_o,
   output logic                            eof_o,
   output logic                            overflow_o
);

   localparam int FW    = NUM_CH * SAMPLE_W;
   localparam int OW    = CH_PER_BEAT * 2 * SAMPLE_W;
   localparam int BEATS = NUM_CH / CH_PER_BEAT;
   localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);

   // First state entered for a new frame, and whether that first beat is
   // already the last one.
`ifdef IQ_FRAME_SERIALIZER_HDR_EN
   localparam ser_state_t START_ST  = ST_HDR;
   localparam logic       START_EOF = 1'b0;
`else
   localparam ser_state_t START_ST  = ST_SEND;
   localparam logic       START_EOF = (BEATS == 1);
`endif

   ser_state_t     state;
   logic [BCW-1:0] beat_cnt;
   logic           fire;
   logic           pop;
   logic           accept;
   logic           drop;
   logic [1:0]     occ;
   logic [1:0]     occ_after;
   logic [FW-1:0]  head_i;
   logic [FW-1:0]  head_q;
   logic [OW-1:0]  beat_data;

   assign fire      = data_valid_o & data_ready_i;
   assign pop       = fire & (state == ST_SEND) & (beat_cnt == LAST_BEAT);
   // Occupancy as it will be after this edge: decides restart vs idle.
   assign occ_after = occ + 2'(accept) - 2'(pop);

   iq_frame_buffer #(
      .FRAME_W (FW)
   ) u_buf (
      .clk_i     (clk_i),
      .reset_ni  (reset_ni),
      .push_req  (data_valid_i),
      .pop       (pop),
      .wr_i_data (I_data_i),
      .wr_q_data (Q_data_i),
      .rd_i_data (head_i),
      .rd_q_data (head_q),
      .occ       (occ),
      .accept    (accept),
      .drop      (drop)
   );

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register here samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state        <= ST_IDLE;
         beat_cnt     <= '0;
         data_valid_o <= 1'b0;
         sof_o        <= 1'b0;
         eof_o        <= 1'b0;
         overflow_o   <= 1'b0;
      end else begin
         if (drop) overflow_o <= 1'b1;

         case (state)
            ST_IDLE: begin
               // A frame captured this edge is presented on the next cycle.
               if (occ_after != 2'd0) begin
                  state        <= START_ST;
                  beat_cnt     <= '0;
                  data_valid_o <= 1'b1;
                  sof_o        <= 1'b1;
                  eof_o        <= START_EOF;
               end
            end
            ST_HDR: begin
               if (fire) begin
                  state    <= ST_SEND;
                  beat_cnt <= '0;
                  sof_o    <= 1'b0;
                  eof_o    <= (LAST_BEAT == '0);
               end
            end
            ST_SEND: begin
               if (fire) begin
                  if (beat_cnt == LAST_BEAT) begin
                     beat_cnt <= '0;
                     if (occ_after != 2'd0) begin
                        state        <= START_ST;
                        data_valid_o <= 1'b1;
                        sof_o        <= 1'b1;
                        eof_o        <= START_EOF;
                     end else begin
                        state        <= ST_IDLE;
                        data_valid_o <= 1'b0;
                        sof_o        <= 1'b0;
                        eof_o        <= 1'b0;
                     end
                  end else begin
                     beat_cnt <= beat_cnt + 1'b1;
                     sof_o    <= 1'b0;
                     eof_o    <= (BCW'(beat_cnt + 1'b1) == LAST_BEAT);
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef IQ_FRAME_SERIALIZER_HDR_EN
   // Counts frames whose header has been sent; frames leave in arrival order,
   // so this equals the accepted-frame index of the frame being headed.
   logic [15:0] hdr_cnt;

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni)                    hdr_cnt <= '0;
      else if (fire && state == ST_HDR) hdr_cnt <= hdr_cnt + 1'b1;
   end
`endif

   // NOTE: beat_data is given a full default before any conditional write so
   // this block can never infer a latch.
   always_comb begin
      int lo;
      beat_data = '0;
      for (int k = 0; k < CH_PER_BEAT; k++) begin
         lo = SAMPLE_W * (CH_PER_BEAT * int'(beat_cnt) + k);
         beat_data[2*SAMPLE_W*k +: SAMPLE_W]          = head_i[lo +: SAMPLE_W];
         beat_data[2*SAMPLE_W*k + SAMPLE_W +: SAMPLE_W] = head_q[lo +: SAMPLE_W];
      end
`ifdef IQ_FRAME_SERIALIZER_HDR_EN
      if (state == ST_HDR) begin
         beat_data       = '0;
         beat_data[31:0] = {HDR_TAG, hdr_cnt};
      end
`endif
   end

   // Gated by the registered valid so reset forces data_o to 0 at once and
   // unreset storage never leaks onto the bus.
   assign data_o = data_valid_o ? beat_data : '0;

endmodule

// File: doc/iq_frame_serializer.md
IQ_FRAME_SERIALIZER -- requirements
Module: iq_frame_serializer

Interface
REQ-001 SHALL have parameter NUM_CH, default 128: channels per frame.
REQ-002 SHALL have parameter SAMPLE_W, default 10: bits per I or Q sample.
REQ-003 SHALL have parameter CH_PER_BEAT, default 16: channels per output beat; NUM_CH divisible by CH_PER_BEAT.
REQ-004 SHALL use one clock and an asynchronous active-low reset: clk_i  input  1  rising-edge clock.
REQ-005 reset_ni  input  1  asynchronous active-low reset.
REQ-006 I_data_i  input  NUM_CH*SAMPLE_W  in-phase frame; channel c at bits [SAMPLE_W*c+SAMPLE_W-1 : SAMPLE_W*c].
REQ-007 Q_data_i  input  NUM_CH*SAMPLE_W  quadrature frame, same packing.
REQ-008 data_valid_i  input  1  single-cycle frame strobe from the upstream I/Q compression stage.
REQ-009 data_o  output  CH_PER_BEAT*2*SAMPLE_W  output beat.
REQ-010 data_valid_o  output  1  beat valid.
REQ-011 data_ready_i  input  1  downstream ready.
REQ-012 sof_o / eof_o  output  1 each  first / last beat of a frame.
REQ-013 overflow_o  output  1  sticky: a frame was dropped.

Function
REQ-014 Beat b, lane k SHALL carry channel c=CH_PER_BEAT*b+k: I at bits [2*SAMPLE_W*k+SAMPLE_W-1 : 2*SAMPLE_W*k], Q in the next SAMPLE_W bits.
REQ-015 Frame length SHALL be NUM_CH/CH_PER_BEAT data beats (8 at defaults), sent in ascending b.
REQ-016 Storage SHALL be a 2-slot frame buffer (write ptr, read ptr, occupancy 0..2); frames leave in arrival order.
REQ-017 A beat SHALL transfer on a cycle with data_valid_o=1 and data_ready_i=1.
REQ-018 While data_valid_o=1 and data_ready_i=0, data_o, sof_o and eof_o SHALL hold stable.
REQ-019 data_valid_o SHALL NOT depend combinationally on data_ready_i.
REQ-020 Latency: frame captured at edge N into an empty buffer -> its first beat valid in the cycle after edge N.
REQ-021 With data_ready_i held 1, beats of one frame SHALL be on consecutive cycles, and the next buffered frame SHALL follow without a gap.
REQ-022 Output FSM states: IDLE (occupancy 0), SEND (beat counter 0..last); IDLE->SEND when occupancy>0; SEND->IDLE after eof transfer with occupancy 0 afterwards; otherwise SEND restarts at beat 0.
REQ-023 data_valid_i with occupancy 2 SHALL drop the incoming frame and set overflow_o; stored frames are untouched.
REQ-024 data_valid_i in the same cycle as the eof transfer at occupancy 2 SHALL be accepted (slot freed that cycle); overflow_o unchanged.
REQ-025 Beat counter and pointers SHALL wrap modulo beats-per-frame and 2 respectively.

Reset
REQ-026 Asserting reset_ni low SHALL immediately force data_valid_o, sof_o, eof_o, overflow_o to 0, occupancy, pointers, beat counter to 0, FSM to IDLE; data_o to 0.
REQ-027 A frame in flight at reset SHALL be discarded; no residual beats after release.
REQ-028 overflow_o SHALL clear only on reset.

Configuration
REQ-029 Macro IQ_FRAME_SERIALIZER_HDR_EN defined: each frame SHALL be preceded by one header beat (state HDR between IDLE and SEND) carrying bits[15:0] accepted-frame count (first frame 0, wraps 65535->0), bits[31:16] 16'hA5C3, rest 0; sof_o on header, not on data beat 0; latency REQ-020 unchanged (header first).
REQ-030 Macro undefined: no header beat, no frame counter logic; sof_o on data beat 0.

Structure
REQ-031 Shared package iq_ser_pkg SHALL hold NUM_CH/SAMPLE_W/CH_PER_BEAT defaults, derived BEATS_PER_FRAME, header tag constant, FSM state enum.
REQ-032 The 2-slot frame store with pointer/occupancy logic SHALL be a sub-module iq_frame_buffer; beat muxing and FSM stay in the top.

Verification
REQ-033 One frame, I[c]=c, Q[c]=c+128, ready=1 -> 8 beats on consecutive cycles from cycle after capture; beat b lane k I=16b+k, Q=16b+k+128; sof on beat 0, eof on beat 7.
REQ-034 Same frame, ready low on cycles 2..5 of frame -> beat 2 held stable for 4 cycles, 8 distinct beats total, none duplicated.
REQ-035 ready=0, frames A,B,C at 22-cycle spacing -> overflow_o=1 after C; on ready=1 output is A then B (16 beats), C never appears.
REQ-036 Occupancy 2, data_valid_i coincident with eof transfer -> frame accepted, overflow_o stays 0, three frames emitted in order.
REQ-037 Reset asserted during beat 3 -> all outputs 0 at once; after release no beats until next data_valid_i, which starts at beat 0 with sof_o.
REQ-038 With IQ_FRAME_SERIALIZER_HDR_EN, two frames -> 9 beats each; headers 0xA5C3_0000 then 0xA5C3_0001 in bits[31:0], sof_o on headers.
